dma_wr_arbiter: RTL and testbench
=================================

# dma_wr_arbiter

Round-robin write arbiter that shares the single Avalon-MM SDRAM write port between NCH line-scanner DMA write masters. Each master holds its request until it is served. A granted master keeps the port for up to RUN_MAX accepted beats, which preserves SDRAM row locality, and the grant then rotates. The block sits between the per-sensor DMA engines and the SDRAM controller write port and replaces fixed time-slot muxing with demand-driven, zero-bubble arbitration.

## Interface
- NCH, 3: number of DMA write masters (2..8).
- DW, 128: data width.
- AW, 28: address width.
- RUN_MAX, 16: maximum accepted beats per grant (1..256).

- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- DMA_DATA  in  NCH*DW  write data. Channel i occupies bits [i*DW +: DW].
- DMA_ADR  in  NCH*AW  word address. Channel i occupies bits [i*AW +: AW].
- DMA_WR  in  NCH  write request per channel, Avalon semantics.
- DMA_WAITREQ  out  NCH  per-channel waitrequest.
- SDRAM_WRITEDATA  out  DW  granted channel's data.
- SDRAM_ADDRESS  out  AW  granted channel's address.
- SDRAM_WRITE  out  1  write strobe.
- SDRAM_WAITREQUEST  in  1  controller stall.
- GRANT  out  NCH  one-hot current grant, or 0 when idle.

## Operation
- Registered state:
  - state IDLE/BUSY.
  - gnt index g.
  - last-served pointer lp.
  - run counter rc, 8 bit.
- Master rule: a master asserting DMA_WR holds DMA_WR, DMA_DATA and DMA_ADR stable until it sees DMA_WAITREQ[i]=0 at a rising edge.
- Beat accept condition: BUSY && DMA_WR[g] && !SDRAM_WAITREQUEST.
- IDLE:
  - SDRAM_WRITE=0.
  - DMA_WAITREQ all 1.
  - If any DMA_WR is set, select the first requester searching from lp+1 mod NCH upward, wrapping. Then go BUSY with g=selected, lp=selected, rc=0.
- BUSY outputs:
  - SDRAM_WRITEDATA, SDRAM_ADDRESS and SDRAM_WRITE are the combinational mux of channel g.
  - DMA_WAITREQ[g]=SDRAM_WAITREQUEST. All other channels are held at 1.
- BUSY, on each accepted beat: rc increments.
- BUSY, release occurs when either:
  - the accepted beat has rc==RUN_MAX-1, or
  - DMA_WR[g]==0.
- BUSY, on release: run the arbitration from lp+1 in the same cycle.
  - If a requester is found, load the new g, lp and rc=0 and stay in BUSY. This gives back-to-back grants with no idle cycle.
  - The search wraps, so the sole requester re-wins.
  - If there are no requesters, go to IDLE.
- Simultaneous requests are resolved purely by rotation. Under continuous demand no channel waits more than (NCH-1)*RUN_MAX accepted beats.
- Data and address are never registered. Block latency adds no pipeline stage to the write path.

## Timing
- Reset values (asynchronous, while RST_N=0):
  - state=IDLE, lp=NCH-1 so channel 0 wins first, rc=0, g=0.
  - SDRAM_WRITE=0, DMA_WAITREQ all 1, GRANT=0.
  - SDRAM_WRITEDATA and SDRAM_ADDRESS are don't-care (they follow channel 0).
- First grant: DMA_WR rises at edge n while in IDLE. GRANT and SDRAM_WRITE are set in cycle n+1. The earliest accept is edge n+2.
- Stall: SDRAM_WAITREQUEST=1 freezes rc and the grant. Release is never taken on a stalled beat.
- Reset mid-beat: the beat is dropped. The master still sees waitrequest=1 and must retry after reset.

## Configuration
- DMA_WR_ARB_PRIO0_EN defined:
  - Channel 0 is strict priority.
  - At each arbitration, DMA_WR[0]=1 wins regardless of lp.
  - An active grant to another channel is released after its current accepted beat whenever DMA_WR[0]=1.
  - Channels 1..NCH-1 round-robin among themselves.
- Undefined: pure round-robin as described above.

## Test plan
- Reset, then DMA_WR=3'b111 held with SDRAM_WAITREQUEST=0 and RUN_MAX=4 -> GRANT sequence 001,010,100,001 with 4 beats each and no idle cycles between grants.
- Channel 1 only, 10 beats, RUN_MAX=4 -> re-granted continuously. SDRAM_ADDRESS and SDRAM_WRITEDATA match channel 1 for all 10 beats, and SDRAM_WRITE stays 1.
- Channel 2 granted, SDRAM_WAITREQUEST=1 for 5 cycles -> DMA_WAITREQ=3'b111, rc unchanged, grant unchanged. The beat is accepted on the first cycle after waitrequest drops.
- Channel 0 drops DMA_WR after 2 beats while channel 1 is requesting -> GRANT switches to 010 on the next cycle and channel 0 is not served again until channel 1 releases.
- RST_N pulsed low during an active grant to channel 1 -> SDRAM_WRITE=0 and DMA_WAITREQ=3'b111 immediately. After reset, channel 0 wins first.
- DMA_WR_ARB_PRIO0_EN defined, channel 2 mid-run, DMA_WR[0] rises -> channel 2 is released after its current accepted beat and GRANT=001 on the next cycle.

Source files
------------

// File: rtl/dma_wr_arbiter.sv
// rtl/dma_wr_arbiter.sv - round-robin SDRAM write-port arbiter for NCH DMA masters, RUN_MAX beats per grant
// DMA_WR_ARB_PRIO0_EN: channel 0 becomes strict priority and preempts other grants after their current beat.
module dma_wr_arbiter #(
  parameter int NCH     = 3,
  parameter int DW      = 128,
  parameter int AW      = 28,
  parameter int RUN_MAX = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NCH*DW-1:0] DMA_DATA,
  input  logic [NCH*AW-1:0] DMA_ADR,
  input  logic [NCH-1:0]    DMA_WR,
  output logic [NCH-1:0]    DMA_WAITREQ,
  output logic [DW-1:0]     SDRAM_WRITEDATA,
  output logic [AW-1:0]     SDRAM_ADDRESS,
  output logic              SDRAM_WRITE,
  input  logic              SDRAM_WAITREQUEST,
  output logic [NCH-1:0]    GRANT
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] lp_q, lp_d;
  logic [7:0]    rc_q, rc_d;

  logic [NCH-1:0] req_rr;
  logic [GW:0]    idx;
  logic           found;
  logic [GW-1:0]  pick;
  logic           busy;
  logic           accept;
  logic           release_g;

  // Rotating search starting one past the last-served channel; wraps so a sole requester re-wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
`ifdef DMA_WR_ARB_PRIO0_EN
    req_rr = DMA_WR & ~{{(NCH-1){1'b0}}, 1'b1};
`else
    req_rr = DMA_WR;
`endif
    for (int k = 1; k <= NCH; k++) begin
      idx = {1'b0, lp_q} + (GW+1)'(k);
      if (idx >= (GW+1)'(NCH)) idx = idx - (GW+1)'(NCH);
      if (!found && req_rr[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
`ifdef DMA_WR_ARB_PRIO0_EN
    if (DMA_WR[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`endif
  end

  assign busy   = (state_q == S_BUSY);
  assign accept = busy && DMA_WR[g_q] && !SDRAM_WAITREQUEST;

`ifdef DMA_WR_ARB_PRIO0_EN
  assign release_g = busy && (!DMA_WR[g_q] || (accept && (rc_q == 8'(RUN_MAX-1)))
                              || (accept && DMA_WR[0] && (g_q != '0)));
`else
  assign release_g = busy && (!DMA_WR[g_q] || (accept && (rc_q == 8'(RUN_MAX-1))));
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    lp_d    = lp_q;
    rc_d    = rc_q;
    if (!busy || release_g) begin
      if (found) begin
        state_d = S_BUSY;
        g_d     = pick;
        lp_d    = pick;
        rc_d    = 8'd0;
      end else begin
        state_d = S_IDLE;
      end
    end else if (accept) begin
      rc_d = rc_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      lp_q    <= GW'(NCH-1);
      rc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      lp_q    <= lp_d;
      rc_q    <= rc_d;
    end
  end

  // Write path is a pure mux of the granted channel: no added pipeline stage.
  always_comb begin
    SDRAM_WRITEDATA = DMA_DATA[int'(g_q)*DW +: DW];
    SDRAM_ADDRESS   = DMA_ADR[int'(g_q)*AW +: AW];
    SDRAM_WRITE     = busy && DMA_WR[g_q];
    DMA_WAITREQ     = '1;
    GRANT           = '0;
    if (busy) begin
      DMA_WAITREQ[g_q] = SDRAM_WAITREQUEST;
      GRANT[g_q]       = 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// tb/tb_dma_wr_arbiter.sv - table-driven bench for dma_wr_arbiter
module tb_dma_wr_arbiter;

  localparam int NCH     = 3;
  localparam int DW      = 16;
  localparam int AW      = 8;
  localparam int RUN_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*DW-1:0] dma_data;
  logic [NCH*AW-1:0] dma_adr;
  logic [NCH-1:0]    dma_wr;
  logic [NCH-1:0]    dma_waitreq;
  logic [DW-1:0]     sdram_writedata;
  logic [AW-1:0]     sdram_address;
  logic              sdram_write;
  logic              sdram_waitrequest;
  logic [NCH-1:0]    grant;

  always #5 clk = ~clk;

  dma_wr_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .RUN_MAX(RUN_MAX)) dut (
    .CLK(clk), .RST_N(rst_n), .DMA_DATA(dma_data), .DMA_ADR(dma_adr), .DMA_WR(dma_wr),
    .DMA_WAITREQ(dma_waitreq), .SDRAM_WRITEDATA(sdram_writedata), .SDRAM_ADDRESS(sdram_address),
    .SDRAM_WRITE(sdram_write), .SDRAM_WAITREQUEST(sdram_waitrequest), .GRANT(grant)
  );

  typedef struct {
    logic [2:0] wr;
    logic       sw;
    logic [2:0] gnt;
    logic       wrt;
    logic [2:0] wq;
  } vec_t;

  vec_t vecs[$];
  int   cnt[NCH];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic [2:0] wr, input logic sw, input logic [2:0] gnt,
                     input logic wrt, input logic [2:0] wq, input int rep);
    vec_t v;
    v.wr = wr; v.sw = sw; v.gnt = gnt; v.wrt = wrt; v.wq = wq;
    repeat (rep) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NCH; i++) begin
      dma_data[i*DW +: DW] = {4'(i), 12'(cnt[i])};
      dma_adr[i*AW +: AW]  = {2'(i), 6'(cnt[i])};
    end
  endtask

  function automatic int oh2i(input logic [2:0] x);
    for (int i = 0; i < NCH; i++) if (x[i]) return i;
    return 0;
  endfunction

  initial begin
    int  gi;
    logic acc;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    dma_wr = '0;
    sdram_waitrequest = 1'b0;
    rst_n = 1'b0;
    drive_bus();

`ifdef DMA_WR_ARB_PRIO0_EN
    add(3'b100, 0, 3'b000, 0, 3'b111, 1);
    add(3'b100, 0, 3'b100, 1, 3'b011, 1);
    add(3'b101, 0, 3'b100, 1, 3'b011, 1);
    add(3'b101, 0, 3'b001, 1, 3'b110, 1);
    add(3'b100, 0, 3'b001, 0, 3'b110, 1);
    add(3'b100, 0, 3'b100, 1, 3'b011, 1);
    add(3'b000, 0, 3'b100, 0, 3'b011, 1);
    add(3'b000, 0, 3'b000, 0, 3'b111, 1);
`else
    // Full rotation under continuous demand, then idle
    add(3'b111, 0, 3'b000, 0, 3'b111, 1);
    add(3'b111, 0, 3'b001, 1, 3'b110, 4);
    add(3'b111, 0, 3'b010, 1, 3'b101, 4);
    add(3'b111, 0, 3'b100, 1, 3'b011, 4);
    add(3'b111, 0, 3'b001, 1, 3'b110, 1);
    add(3'b000, 0, 3'b001, 0, 3'b110, 1);
    add(3'b000, 0, 3'b000, 0, 3'b111, 1);
    // Sole requester re-granted across run boundaries
    add(3'b010, 0, 3'b000, 0, 3'b111, 1);
    add(3'b010, 0, 3'b010, 1, 3'b101, 10);
    add(3'b000, 0, 3'b010, 0, 3'b101, 1);
    // Stall on channel 2 freezes run count: still exactly 4 beats afterwards
    add(3'b101, 0, 3'b000, 0, 3'b111, 1);
    add(3'b101, 1, 3'b100, 1, 3'b111, 5);
    add(3'b101, 0, 3'b100, 1, 3'b011, 4);
    // Channel 0 drops early; channel 1 takes over for a full run
    add(3'b011, 0, 3'b001, 1, 3'b110, 2);
    add(3'b010, 0, 3'b001, 0, 3'b110, 1);
    add(3'b011, 0, 3'b010, 1, 3'b101, 4);
    add(3'b001, 0, 3'b001, 1, 3'b110, 1);
    add(3'b000, 0, 3'b001, 0, 3'b110, 1);
    add(3'b000, 0, 3'b000, 0, 3'b111, 1);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset write", 32'(sdram_write), 32'h0);
    chk("reset waitreq", 32'(dma_waitreq), 32'h7);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      dma_wr = vecs[k].wr;
      sdram_waitrequest = vecs[k].sw;
      @(negedge clk);
      gi = oh2i(vecs[k].gnt);
      chk($sformatf("v%0d grant", k), 32'(grant), 32'(vecs[k].gnt));
      chk($sformatf("v%0d write", k), 32'(sdram_write), 32'(vecs[k].wrt));
      chk($sformatf("v%0d waitreq", k), 32'(dma_waitreq), 32'(vecs[k].wq));
      if (vecs[k].wrt) begin
        chk($sformatf("v%0d data", k), 32'(sdram_writedata), 32'({4'(gi), 12'(cnt[gi])}));
        chk($sformatf("v%0d addr", k), 32'(sdram_address), 32'({2'(gi), 6'(cnt[gi])}));
      end
      acc = vecs[k].wrt && !vecs[k].wq[gi];
      @(posedge clk);
      #1;
      if (acc) cnt[gi]++;
      drive_bus();
    end

    // Reset asserted during an active grant to channel 1
    dma_wr = 3'b010;
    @(negedge clk);
    chk("rst idle grant", 32'(grant), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst pre grant", 32'(grant), 32'h2);
    chk("rst pre write", 32'(sdram_write), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid write", 32'(sdram_write), 32'h0);
    chk("rst mid waitreq", 32'(dma_waitreq), 32'h7);
    chk("rst mid grant", 32'(grant), 32'h0);
    dma_wr = 3'b011;
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post rst grant", 32'(grant), 32'h1);
    chk("post rst write", 32'(sdram_write), 32'h1);
    chk("post rst waitreq", 32'(dma_waitreq), 32'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
